// File: rtl/micro_processor.sv
// micro_processor: 8-bit stack-machine core executing one bytecode instruction per clock
module micro_processor (
  input  logic              clk,
  input  logic              rst,
  input  logic [1023:0][7:0] memory,
  input  logic              enable,
  output logic [7:0]        result,
  output logic              running
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_n;
  logic [9:0] pc, pc_n, tgt;
  logic [4:0] sp, sp_n, sp_x, pop1, pop2;
  logic [7:0] stk [16];
  logic [7:0] op, o1, o2, a, b, val, tos, result_n;
  logic [3:0] wi;
  logic [1:0] len;
  logic [10:0] nxt;
  logic wr, we, jump, ovf, halt_op, running_n;
  // instruction decode and stack effect of the opcode at pc
  always_comb begin
    op = memory[pc];
    o1 = memory[pc + 10'd1];
    o2 = memory[pc + 10'd2];
    b = sp != 5'd0 ? stk[sp[3:0] - 4'd1] : 8'h00;
    a = sp > 5'd1 ? stk[sp[3:0] - 4'd2] : 8'h00;
    pop1 = sp != 5'd0 ? sp - 5'd1 : 5'd0;
    pop2 = sp > 5'd1 ? sp - 5'd2 : 5'd0;
    tgt = {o1[1:0], o2};
    val = 8'h00;
    wr = 1'b0;
    wi = sp[3:0];
    sp_x = sp;
    len = 2'd1;
    case (op)
      8'h01, 8'h08: begin
        val = op == 8'h01 ? o1 : b;
        wr = !sp[4];
        sp_x = sp[4] ? sp : sp + 5'd1;
        len = op == 8'h01 ? 2'd2 : 2'd1;
      end
      8'h02: sp_x = pop1;
      8'h03, 8'h04, 8'h05, 8'h06, 8'h07: begin
        val = op == 8'h03 ? a + b : op == 8'h04 ? a - b : op == 8'h05 ? a & b : op == 8'h06 ? a | b : a ^ b;
        wr = 1'b1;
        wi = pop2[3:0];
        sp_x = pop2 + 5'd1;
      end
      8'h09: len = 2'd3;
      8'h0A: begin
        sp_x = pop1;
        len = 2'd3;
      end
      default: len = 2'd1;
    endcase
    nxt = {1'b0, pc} + {9'd0, len};
    jump = op == 8'h09 || (op == 8'h0A && b == 8'h00);
    halt_op = op == 8'hFF;
    ovf = !jump && nxt[10];
    tos = sp_x == 5'd0 ? 8'h00 : wr ? val : stk[sp_x[3:0] - 4'd1];
  end
  // state and architectural registers; reset clears everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= 10'd0;
      sp <= 5'd0;
      result <= 8'h00;
      running <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      sp <= sp_n;
      result <= result_n;
      running <= running_n;
    end
  end
  // stack storage needs no reset: only entries below sp are ever read
  always_ff @(posedge clk) begin
    if (we) stk[wi] <= val;
  end
  // next-state: HALT on the halt opcode or when pc would run past the end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = enable ? RUN : IDLE;
      RUN: state_n = enable && (halt_op || ovf) ? HALT : RUN;
      HALT: state_n = enable ? HALT : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs and datapath updates; a paused RUN holds everything
  always_comb begin
    pc_n = pc;
    sp_n = sp;
    result_n = result;
    running_n = running;
    we = 1'b0;
    if (state == IDLE && enable) begin
      pc_n = 10'd0;
      sp_n = 5'd0;
      result_n = 8'h00;
      running_n = 1'b1;
    end else if (state == RUN && enable && halt_op) begin
      running_n = 1'b0;
    end else if (state == RUN && enable) begin
      we = wr;
      sp_n = sp_x;
      result_n = tos;
      pc_n = jump ? tgt : ovf ? pc : nxt[9:0];
      running_n = !ovf;
    end else if (state == HALT) begin
      running_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_micro_processor.sv
// tb_micro_processor: directed bytecode programs with hand-computed results
module tb_micro_processor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [1023:0][7:0] memory;
  logic [7:0] result;
  logic running;
  int n_tests = 0;
  int n_fail = 0;
  int cyc;
  logic [7:0] p [$];

  micro_processor dut (
    .clk(clk),
    .rst(rst),
    .memory(memory),
    .enable(enable),
    .result(result),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] prog [$]);
    memory = '0;
    for (int i = 0; i < prog.size(); i++) memory[i] = prog[i];
  endtask

  // counts edges from the one that samples enable up to the one where running falls
  task automatic run_to_halt(input int budget, output int c);
    c = 0;
    forever begin
      step();
      c++;
      if (!running || c >= budget) break;
    end
  endtask

  task automatic go(input string tag, input int budget, input int exp_cyc, input logic [7:0] exp_res);
    enable = 1'b1;
    run_to_halt(budget, cyc);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_running"}, running, 0);
    enable = 1'b0;
    step();
  endtask

  initial begin
    memory = '0;
    #1;
    chk("reset_result", result, 8'h00);
    chk("reset_running", running, 0);
    step();
    rst = 1'b0;
    step();

    p = '{8'h01, 8'h05, 8'h01, 8'h03, 8'h03, 8'hFF};
    load(p);
    go("add", 20, 5, 8'h08);
    go("rerun", 20, 5, 8'h08);

    p = '{8'h01, 8'h03, 8'h01, 8'h05, 8'h04, 8'hFF};
    load(p);
    go("sub", 20, 5, 8'hFE);

    p = '{8'h01, 8'hF0, 8'h01, 8'h3C, 8'h07, 8'hFF};
    load(p);
    go("xor", 20, 5, 8'hCC);

    p = '{8'h01, 8'h03, 8'h01, 8'h01, 8'h04, 8'h08, 8'h0A, 8'h00, 8'h0C, 8'h09, 8'h00, 8'h02, 8'hFF};
    load(p);
    go("loop", 50, 17, 8'h00);

    p = '{8'h01, 8'h05, 8'h01, 8'h03, 8'h03, 8'hFF};
    load(p);
    enable = 1'b1;
    step();
    chk("pause_start_running", running, 1);
    step();
    chk("pause_first_push", result, 8'h05);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_hold_result", result, 8'h05);
      chk("pause_hold_running", running, 1);
    end
    enable = 1'b1;
    run_to_halt(20, cyc);
    chk("pause_resume_cycles", cyc, 3);
    chk("pause_resume_result", result, 8'h08);
    enable = 1'b0;
    step();

    p = {};
    for (int i = 0; i < 17; i++) begin
      p.push_back(8'h01);
      p.push_back(8'h01);
    end
    for (int i = 0; i < 16; i++) p.push_back(8'h03);
    p.push_back(8'hFF);
    load(p);
    go("full", 60, 35, 8'h10);

    p = '{8'h02, 8'hFF};
    load(p);
    go("pop_empty", 20, 3, 8'h00);

    p = '{8'h02, 8'h01, 8'h09, 8'hFF};
    load(p);
    go("pop_empty_push", 20, 4, 8'h09);

    memory = '0;
    go("run_off_end", 1100, 1025, 8'h00);

    p = '{8'h01, 8'h03, 8'h01, 8'h01, 8'h04, 8'h08, 8'h0A, 8'h00, 8'h0C, 8'h09, 8'h00, 8'h02, 8'hFF};
    load(p);
    enable = 1'b1;
    step();
    step();
    chk("midrun_result", result, 8'h03);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_result", result, 8'h00);
    chk("async_rst_running", running, 0);
    step();
    rst = 1'b0;
    run_to_halt(50, cyc);
    chk("restart_cycles", cyc, 17);
    chk("restart_result", result, 8'h00);
    enable = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
